pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-flow controller that owns the CPU program counter and sequences it. Provides a start/done handshake to the testbench/top level, a one-cycle priming state after start, and per-cycle next-PC selection: increment, branch/jump, subroutine call and return through a small hardware return-address stack. It sits between the decoder/ALU flags and instruction memory and replaces the bare counter in the fetch path.

Parameters:
A, 10, program-counter / instruction-address width
DEPTH, 4, return-address stack entries (≥1)

Ports:
clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin (or restart) execution at address 0; sampled only in IDLE or DONE
Halt  in  1  decoded halt instruction at current PC
BranchTaken  in  1  conditional branch resolved taken this cycle
Jump  in  1  unconditional absolute jump
Call  in  1  subroutine call to Target
Ret  in  1  return from subroutine
Target  in  A  absolute target for branch/jump/call
ProgCtr  out  A  current instruction address
Running  out  1  high only in RUN
Done  out  1  high (level) while in DONE
Fault  out  1  sticky stack overflow/underflow flag
StackDepth  out  $clog2(DEPTH+1)  number of valid stack entries

Behaviour:
- States: IDLE, PRIME, RUN, DONE. Reset (any state, any cycle, including mid-RUN) -> IDLE, ProgCtr=0, stack emptied, StackDepth=0, Fault=0, Running=0, Done=0.
- IDLE: ProgCtr held at 0. Start=1 -> PRIME next cycle.
- PRIME: exactly one cycle; ProgCtr=0, Running=0; all control inputs ignored; -> RUN unconditionally.
- RUN: Running=1; ProgCtr updates every cycle per fixed priority (first match wins):
  1. Halt: ProgCtr held; -> DONE.
  2. Ret: if StackDepth=0 -> Fault<=1, ProgCtr held, -> DONE; else ProgCtr<=top entry, StackDepth-1.
  3. Call: if StackDepth=DEPTH -> Fault<=1, ProgCtr held, -> DONE; else push ProgCtr+1 (mod 2^A), ProgCtr<=Target, StackDepth+1.
  4. Jump or BranchTaken: ProgCtr<=Target.
  5. Otherwise ProgCtr<=ProgCtr+1, wrapping 2^A-1 -> 0 with no flag.
- Lower-priority inputs asserted simultaneously with a higher one are dropped, not deferred.
- DONE: Done=1, Running=0, ProgCtr and stack held, control inputs ignored. Start=1 -> ProgCtr<=0, stack emptied, Fault<=0, -> PRIME.
- Control inputs (Halt/Ret/Call/Jump/BranchTaken) have no effect in IDLE, PRIME and DONE; Start has no effect in PRIME and RUN.
- Stack is LIFO, registered; push and pop never occur in the same cycle (priority guarantees this). A pushed value is readable by a Ret in the very next cycle.
- Latency: inputs sampled at edge N take effect on ProgCtr/state at edge N; outputs are purely registered-state decodes (no combinational input-to-output paths).
- Fault sets only on overflow/underflow; cleared only by Reset or restart from DONE.

Test Plan:
- Reset, Start pulse at cycle 2 -> cycle 3 PRIME (ProgCtr=0, Running=0), cycles 4..8 RUN with ProgCtr 0,1,2,3,4; Halt at ProgCtr=4 -> DONE, Done=1, ProgCtr stays 4.
- In RUN at ProgCtr=5: Jump, Target=0x100 -> ProgCtr=0x100; BranchTaken+Jump together, Target=0x3FF -> ProgCtr=0x3FF, next cycle wraps to 0.
- At ProgCtr=0x010: Call Target=0x200 -> ProgCtr=0x200, StackDepth=1; two cycles later Ret -> ProgCtr=0x011, StackDepth=0.
- DEPTH=4: five nested Calls -> fifth sets Fault=1, state DONE, ProgCtr held, StackDepth=4; Ret with empty stack likewise -> Fault=1, DONE.
- Halt+Call+Ret same cycle -> Halt wins: DONE, stack unchanged; Start in DONE -> PRIME, ProgCtr=0, Fault=0, StackDepth=0.
- Reset asserted mid-RUN at ProgCtr=0x037 with StackDepth=2 -> next cycle IDLE, ProgCtr=0, StackDepth=0, Running=0; Jump/Start held during PRIME have no effect.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/done handshake, one-cycle prime state, and next-PC selection
// (increment, branch/jump, call/return via a small return-address stack).
module pc_sequencer #(
    parameter int unsigned A     = 10,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned SW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          BranchTaken,
    input  logic          Jump,
    input  logic          Call,
    input  logic          Ret,
    input  logic [A-1:0]  Target,
    output logic [A-1:0]  ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic          Fault,
    output logic [SW-1:0] StackDepth
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [A-1:0]    pc_q, pc_d;
    logic [SW-1:0]   sp_q, sp_d;
    logic            fault_q, fault_d;
    logic            push;
    logic [A-1:0]    stack_q [DEPTH];
    logic [IW-1:0]   push_idx, pop_idx;
    logic [A-1:0]    pc_inc;

    assign pc_inc   = pc_q + A'(1);
    assign push_idx = IW'(sp_q);
    assign pop_idx  = IW'(sp_q - SW'(1));

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            sp_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    // Stack contents need no reset: only entries below sp_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        fault_d = fault_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                pc_d = '0;
                if (Start) begin
                    state_d = StPrime;
                end
            end
            StPrime: begin
                pc_d    = '0;
                state_d = StRun;
            end
            StRun: begin
                if (Halt) begin
                    state_d = StDone;
                end else if (Ret) begin
                    if (sp_q == '0) begin
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        pc_d = stack_q[pop_idx];
                        sp_d = sp_q - SW'(1);
                    end
                end else if (Call) begin
                    if (sp_q == SW'(DEPTH)) begin
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        push = 1'b1;
                        pc_d = Target;
                        sp_d = sp_q + SW'(1);
                    end
                end else if (Jump || BranchTaken) begin
                    pc_d = Target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            StDone: begin
                if (Start) begin
                    state_d = StPrime;
                    pc_d    = '0;
                    sp_d    = '0;
                    fault_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Running = (state_q == StRun);
        Done    = (state_q == StDone);
    end

    assign ProgCtr    = pc_q;
    assign Fault      = fault_q;
    assign StackDepth = sp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer with a few hand-written multi-cycle sequences.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       Reset, Start, Halt, BranchTaken, Jump, Call, Ret;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic       Running, Done, Fault;
    logic [2:0] StackDepth;

    int tests  = 0;
    int failed = 0;

    pc_sequencer #(.A(10), .DEPTH(4)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .BranchTaken(BranchTaken),
        .Jump       (Jump),
        .Call       (Call),
        .Ret        (Ret),
        .Target     (Target),
        .ProgCtr    (ProgCtr),
        .Running    (Running),
        .Done       (Done),
        .Fault      (Fault),
        .StackDepth (StackDepth)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, halt, ret, call, jump, br;
        logic [9:0] target;
        logic [9:0] pc;
        logic       run, done, fault;
        logic [2:0] depth;
    } vec_t;

    vec_t vecs [33];

    function automatic vec_t mk(input logic st, input logic h, input logic r, input logic c,
                                input logic j, input logic b, input logic [9:0] t,
                                input logic [9:0] pc, input logic run, input logic dn,
                                input logic f, input logic [2:0] d);
        vec_t v;
        v.start = st; v.halt = h; v.ret = r; v.call = c; v.jump = j; v.br = b;
        v.target = t; v.pc = pc; v.run = run; v.done = dn; v.fault = f; v.depth = d;
        return v;
    endfunction

    task automatic drive(input logic st, input logic h, input logic r, input logic c,
                         input logic j, input logic b, input logic [9:0] t);
        Start = st; Halt = h; Ret = r; Call = c; Jump = j; BranchTaken = b; Target = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [9:0] pc, input logic run, input logic dn,
                       input logic f, input logic [2:0] d);
        tests++;
        if (ProgCtr !== pc || Running !== run || Done !== dn || Fault !== f
            || StackDepth !== d) begin
            failed++;
            $display("FAIL %s: got pc=%h run=%b done=%b fault=%b depth=%0d, want pc=%h run=%b done=%b fault=%b depth=%0d",
                     nm, ProgCtr, Running, Done, Fault, StackDepth, pc, run, dn, f, d);
        end
    endtask

    initial begin
        //              st h r c j b target   pc     run dn f depth
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0); // -> PRIME
        vecs[1]  = mk(0, 0, 0, 0, 1, 0, 10'h155, 10'h000, 1, 0, 0, 0); // jump ignored in PRIME
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h004, 1, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 10'h000, 10'h004, 0, 1, 0, 0); // halt -> DONE
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 10'h100, 10'h004, 0, 1, 0, 0); // ignored in DONE
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0); // restart -> PRIME
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 10'h005, 10'h005, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 0, 10'h100, 10'h100, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, 1, 10'h3FF, 10'h3FF, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0); // wrap
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 10'h010, 10'h010, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 0, 0, 10'h200, 10'h200, 1, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h201, 1, 0, 0, 1);
        vecs[17] = mk(0, 0, 1, 0, 0, 0, 10'h000, 10'h011, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 1, 0, 0, 10'h020, 10'h020, 1, 0, 0, 1);
        vecs[19] = mk(0, 0, 0, 1, 0, 0, 10'h030, 10'h030, 1, 0, 0, 2);
        vecs[20] = mk(0, 0, 0, 1, 0, 0, 10'h040, 10'h040, 1, 0, 0, 3);
        vecs[21] = mk(0, 0, 0, 1, 0, 0, 10'h050, 10'h050, 1, 0, 0, 4);
        vecs[22] = mk(0, 0, 0, 1, 0, 0, 10'h060, 10'h050, 0, 1, 1, 4); // overflow
        vecs[23] = mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
        vecs[25] = mk(0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 1, 1, 0); // underflow
        vecs[26] = mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
        vecs[28] = mk(0, 0, 0, 1, 0, 0, 10'h080, 10'h080, 1, 0, 0, 1);
        vecs[29] = mk(0, 0, 1, 1, 1, 0, 10'h0AA, 10'h001, 1, 0, 0, 0); // ret beats call/jump
        vecs[30] = mk(0, 0, 0, 1, 0, 0, 10'h090, 10'h090, 1, 0, 0, 1);
        vecs[31] = mk(0, 1, 1, 1, 0, 0, 10'h0BB, 10'h090, 0, 1, 0, 1); // halt wins
        vecs[32] = mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);

        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 10'h000);
        tick();
        tick();
        chk("reset", 10'h000, 0, 0, 0, 0);
        Reset = 1'b0;
        tick();
        chk("idle_hold", 10'h000, 0, 0, 0, 0);

        for (int i = 0; i < 33; i++) begin
            drive(vecs[i].start, vecs[i].halt, vecs[i].ret, vecs[i].call, vecs[i].jump,
                  vecs[i].br, vecs[i].target);
            tick();
            chk($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].fault,
                vecs[i].depth);
        end

        // Build pc=0x037 with two stack entries, then reset mid-RUN.
        drive(0, 0, 0, 0, 0, 0, 10'h000);
        tick();
        chk("seq_run0", 10'h000, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 10'h030);
        tick();
        drive(0, 0, 0, 1, 0, 0, 10'h036);
        tick();
        drive(0, 0, 0, 0, 0, 0, 10'h000);
        tick();
        chk("seq_pre_reset", 10'h037, 1, 0, 0, 2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("seq_reset_midrun", 10'h000, 0, 0, 0, 0);

        // Start and Jump held through PRIME and into RUN.
        drive(1, 0, 0, 0, 1, 0, 10'h123);
        tick();
        chk("seq_prime", 10'h000, 0, 0, 0, 0);
        tick();
        chk("seq_prime_ignored", 10'h000, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 10'h000);
        tick();
        chk("seq_start_in_run", 10'h001, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 10'h000);
        tick();
        chk("seq_run_inc", 10'h002, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
